addsub32_seq: RTL and testbench
===============================

# addsub32_seq

Multi-cycle 32-bit adder/subtractor that time-shares a single 4-bit carry-lookahead slice (`cla4_ov`) across all nibbles of the operands, least-significant nibble first. It is the area-reduced arithmetic path for the `alu32` family. It accepts an operation on a start pulse, walks the slice through WIDTH/4 cycles, and returns the result with N/Z/C/V flags on a one-cycle done pulse.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of 4 (≥ 8).
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a new operation; sampled only when accepted (see Operation).
- `op` input 1: 0 = add (a+b), 1 = subtract (a−b); sampled with `start`.
- `a` input WIDTH: operand A; sampled with `start`.
- `b` input WIDTH: operand B; sampled with `start`.
- `busy` output 1: high while nibbles are being processed.
- `done` output 1: one-cycle pulse; `result`/flags valid from this cycle.
- `result` output WIDTH: sum/difference.
- `n`, `z`, `c`, `v` output 1 each: negative, zero, carry-out (no-borrow on subtract), signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with `start`=1:
  - latch `a` into A_reg and (`op` ? ~`b` : `b`) into B_reg;
  - carry_reg ← `op`; nibble counter k ← 0; go to RUN.
- RUN, each cycle:
  - slice inputs = A_reg[4k+3:4k], B_reg[4k+3:4k], carry_reg;
  - slice sum is written into result[4k+3:4k]; carry_reg ← slice `co`; k ← k+1.
- Last nibble (k = WIDTH/4−1):
  - c ← `co`; v ← `c3` ^ `co`; n ← MSB of the final sum; z ← (full result == 0), evaluated on the completed value;
  - go to DONE.
- DONE: `done`=1 for exactly one cycle. Without `start`, go to IDLE. With `start`, accept the new operation and go directly to RUN.
- `start` in RUN is ignored. Operand/`op` changes after acceptance have no effect.
- `result` and flags hold their last values until the next accepted operation completes its first nibble. Partial nibbles are visible in `result` during RUN and are not valid until `done`.
- Arithmetic is modulo 2^WIDTH. Subtract is two's-complement (A + ~B + 1). `c`=1 on subtract means A ≥ B unsigned.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE, k = 0, `busy`=0, `done`=0;
  - `result`=0, `n`=`z`=`c`=`v`=0, all internal registers 0.
- Latency: `start` sampled at edge E0 → `busy`=1 from E0 through E(WIDTH/4). `done`=1 in the cycle after edge E(WIDTH/4), i.e. 8 cycles after E0 for WIDTH=32.
- Throughput: one operation per WIDTH/4+1 cycles (start in DONE cycle).
- `busy` and `done` are never high together.
- Reset asserted mid-RUN aborts the operation: no `done` pulse, outputs go to reset values. The next `start` after reset release behaves normally.
- All outputs are registered. No combinational path from `start`/`a`/`b` to any output.

## Structure
- Shared package/include holds:
  - state encodings (IDLE/RUN/DONE);
  - OP_ADD=0, OP_SUB=1;
  - NIBBLES = WIDTH/4 and counter width = clog2(NIBBLES).
- One sub-module: a single `cla4_ov` instance as the only adder hardware. Nibble muxing, the carry register and flag logic stay in this block.

## Test plan
- add 0x0000_0001 + 0xFFFF_FFFF → result 0x0000_0000, z=1, c=1, v=0, n=0; `done` exactly 8 cycles after the start edge, `busy` high for 8 cycles.
- add 0x7FFF_FFFF + 0x0000_0001 → 0x8000_0000, v=1, n=1, c=0, z=0.
- sub 5 − 7 → 0xFFFF_FFFE, n=1, c=0, v=0; sub 0x8000_0000 − 1 → 0x7FFF_FFFF, v=1, c=1.
- Pulse `start` with new a/b in RUN cycles 3 and 5, and change a/b every cycle → ignored; first operation's result is unchanged; only one `done`.
- Assert `reset` during nibble 4 → all outputs 0 immediately, no `done`. Then add 0x1234_5678 + 0x1111_1111 → 0x2345_6789, done 8 cycles later.
- Back-to-back: add 3+4, then re-assert `start` (sub 10−3) in the DONE cycle → first `done` shows 7; second `done` 9 cycles later shows 7, c=1, v=0.

Source files
------------

// File: rtl/addsub32_pkg.sv
// Shared constants, opcode values and FSM encoding for the nibble-serial adder/subtractor.
package addsub32_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CNT_W   = $clog2(NIBBLES);

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub32_if.sv
// Request/response bundle between an ALU sequencer and addsub32_seq.
interface addsub32_if;
  import addsub32_pkg::*;

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             n;
  logic             z;
  logic             c;
  logic             v;

  modport master (output start, op, a, b,
                  input  busy, done, result, n, z, c, v);
  modport slave  (input  start, op, a, b,
                  output busy, done, result, n, z, c, v);
endinterface

// File: rtl/addsub32_seq_cla4.sv
// 4-bit carry-lookahead slice; exposes carry into bit 3 so the caller can derive overflow.
module cla4_ov (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g  = a & b;
  assign p  = a ^ b;
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s  = p ^ {c3, c2, c1, ci};
endmodule

// File: rtl/addsub32_seq.sv
// Nibble-serial 32-bit add/subtract: one shared CLA4 slice walked LSB nibble first, flags on done.
module addsub32_seq
  import addsub32_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  addsub32_if.slave  bus
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, result_q;
  logic [CNT_W-1:0]   k_q;
  logic               carry_q;
  logic               busy_q, done_q;
  logic               n_q, z_q, c_q, v_q;
  logic               accept_c, last_c;
  logic [3:0]         nib_a, nib_b, sum;
  logic               co, c3;

  assign nib_a = a_q[{k_q, 2'b00} +: 4];
  assign nib_b = b_q[{k_q, 2'b00} +: 4];

  cla4_ov u_cla (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (sum),
    .co (co),
    .c3 (c3)
  );

  // Next-state: start is only honoured from IDLE or DONE.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (k_q == CNT_W'(NIBBLES - 1)) begin
          last_c  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= last_c;
      if (accept_c) begin
        a_q     <= bus.a;
        b_q     <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
        carry_q <= bus.op;
        k_q     <= '0;
      end else if (state_q == ST_RUN) begin
        result_q[{k_q, 2'b00} +: 4] <= sum;
        carry_q <= co;
        k_q     <= k_q + CNT_W'(1);
        // Zero flag must see the final nibble, which is only landing this edge.
        if (last_c) begin
          c_q <= co;
          v_q <= c3 ^ co;
          n_q <= sum[3];
          z_q <= ({sum, result_q[WIDTH-5:0]} == '0);
        end
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.n      = n_q;
  assign bus.z      = z_q;
  assign bus.c      = c_q;
  assign bus.v      = v_q;

endmodule

// File: tb/tb_addsub32_seq.sv
// Self-checking bench for addsub32_seq: directed corner cases plus random ops against an arithmetic model.
module tb_addsub32_seq;
  import addsub32_pkg::*;

  logic clk = 1'b0;
  logic reset;
  addsub32_if bus();

  addsub32_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] e_res;
  logic        e_n, e_z, e_c, e_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub;
    longint          sa, sb, sr;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (op) begin
      e_res = a - b;
      e_c   = (a >= b);
      sr    = sa - sb;
    end else begin
      e_res = a + b;
      e_c   = (ua + ub) > 64'hFFFF_FFFF;
      sr    = sa + sb;
    end
    e_v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e_n = e_res[31];
    e_z = (e_res == 32'd0);
  endfunction

  task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    model(op, a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Called one sample after the accepting edge; returns at the done cycle.
  task automatic wait_done(input string tag, input bit scramble, output int cyc);
    int busy_cnt;
    busy_cnt = int'(bus.busy);
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      if (scramble) begin
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 1'($urandom_range(0, 1));
        bus.start = (cyc == 2 || cyc == 4);
      end
      @(posedge clk); #1;
      cyc++;
      if (!bus.done) busy_cnt += int'(bus.busy);
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_result"}, bus.result, e_res);
    chk({tag, "_n"}, 32'(bus.n), 32'(e_n));
    chk({tag, "_z"}, 32'(bus.z), 32'(e_z));
    chk({tag, "_c"}, 32'(bus.c), 32'(e_c));
    chk({tag, "_v"}, 32'(bus.v), 32'(e_v));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_result"}, bus.result, 32'd0);
    chk({tag, "_nzcv"}, 32'({bus.n, bus.z, bus.c, bus.v}), 32'd0);
  endtask

  initial begin
    int cyc;
    int extra;
    logic [31:0] ra, rb;

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases
    launch(OP_ADD, 32'h0000_0001, 32'hFFFF_FFFF);
    wait_done("add_wrap_zero", 1'b0, cyc);
    @(posedge clk); #1;
    chk("idle_after_done_done", 32'(bus.done), 32'd0);
    chk("idle_after_done_busy", 32'(bus.busy), 32'd0);
    chk("idle_hold_result", bus.result, 32'h0000_0000);

    launch(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_done("add_ovf", 1'b0, cyc);
    launch(OP_SUB, 32'd5, 32'd7);
    wait_done("sub_neg", 1'b0, cyc);
    launch(OP_SUB, 32'h8000_0000, 32'd1);
    wait_done("sub_ovf", 1'b0, cyc);

    // Start pulses and operand churn during RUN must be ignored
    launch(OP_ADD, 32'hDEAD_BEEF, 32'h0102_0304);
    wait_done("ignore_start", 1'b1, cyc);
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      extra += int'(bus.done);
    end
    chk("ignore_start_extra_done", 32'(extra), 32'd0);
    chk("ignore_start_result_hold", bus.result, e_res);

    // Reset mid-operation aborts it
    launch(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_zero("midrun_reset");
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      extra += int'(bus.done);
    end
    chk("midrun_reset_no_done", 32'(extra), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    launch(OP_ADD, 32'h1234_5678, 32'h1111_1111);
    wait_done("after_reset", 1'b0, cyc);

    // Back-to-back: second start issued in the DONE cycle
    launch(OP_ADD, 32'd3, 32'd4);
    wait_done("b2b_first", 1'b0, cyc);
    launch(OP_SUB, 32'd10, 32'd3);
    wait_done("b2b_second", 1'b0, cyc);
    chk("b2b_gap", 32'(cyc + 1), 32'd9);

    // Random operations, including equal operands
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      launch(1'($urandom_range(0, 1)), ra, rb);
      wait_done("random", 1'b0, cyc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
